mtbuf_rsp_collector: RTL and testbench

- Memory-response side of the LSU MTBUF load path. The address side issues one tagged read per active lane per dword; this block accepts the tagged read responses.
- Scatters each response into a per-lane buffer. Once every active lane of the current dword pass has returned, it issues one masked full-wavefront VGPR write.
- Repeats for up to 4 dword passes, then signals completion per wavefront.

---
 rtl/mtbuf_rsp_collector_pkg.sv | 22 ++
 rtl/mtbuf_rsp_lane_buf.sv | 25 ++
 rtl/mtbuf_rsp_collector.sv | 115 +++++++++++
 tb/tb_mtbuf_rsp_collector.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mtbuf_rsp_collector_pkg.sv
// Shared LSU definitions for the MTBUF load response path: sizes, tag layout, FSM encoding.
package mtbuf_rsp_collector_pkg;

    localparam int NUM_LANES   = 64;
    localparam int DATA_W      = 32;
    localparam int VGPR_ADDR_W = 10;
    localparam int TAG_W       = 8;
    localparam int WFID_W      = 6;

    localparam int TAG_TID_LSB = 0;
    localparam int TAG_TID_W   = 6;
    localparam int TAG_DW_LSB  = 6;
    localparam int TAG_DW_W    = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/mtbuf_rsp_lane_buf.sv
// Per-lane response buffer: one write port indexed by tid, whole array readable as a packed vector.
module mtbuf_rsp_lane_buf
    import mtbuf_rsp_collector_pkg::*;
#(
    parameter int LANES = NUM_LANES,
    parameter int WIDTH = DATA_W,
    parameter int IDX_W = $clog2(LANES)
) (
    input  logic                              clk,
    input  logic                              we,
    input  logic [IDX_W-1:0]                  idx,
    input  logic [WIDTH-1:0]                  wdata,
    output logic [LANES-1:0][WIDTH-1:0]       rdata
);

    logic [LANES-1:0][WIDTH-1:0] mem;

    // No reset: unwritten lanes are always masked off at the VGPR write.
    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
    end

    assign rdata = mem;

endmodule

// File: rtl/mtbuf_rsp_collector.sv
// Collects tagged MTBUF read responses per lane and issues one masked VGPR write per dword pass.
module mtbuf_rsp_collector
    import mtbuf_rsp_collector_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [NUM_LANES-1:0]          start_exec,
    input  logic [VGPR_ADDR_W-1:0]        start_vgpr_dest,
    input  logic [TAG_DW_W-1:0]           start_dword_cnt,
    input  logic [WFID_W-1:0]             start_wfid,
    output logic                          busy,
    input  logic                          mem_ack,
    input  logic [TAG_W-1:0]              mem_tag_resp,
    input  logic [DATA_W-1:0]             mem_rd_data,
    output logic                          vgpr_wr_en,
    input  logic                          vgpr_wr_ready,
    output logic [VGPR_ADDR_W-1:0]        vgpr_wr_addr,
    output logic [NUM_LANES*DATA_W-1:0]   vgpr_wr_data,
    output logic [NUM_LANES-1:0]          vgpr_wr_mask,
    output logic                          done,
    output logic [WFID_W-1:0]             done_wfid,
    output logic                          rsp_err
);

    state_t state_q, state_d;

    logic [NUM_LANES-1:0]   exec_q;
    logic [NUM_LANES-1:0]   pending_q;
    logic [NUM_LANES-1:0]   pending_clr;
    logic [VGPR_ADDR_W-1:0] dest_q;
    logic [TAG_DW_W-1:0]    cnt_q;
    logic [TAG_DW_W-1:0]    pass_q;
    logic [WFID_W-1:0]      wfid_q;
    logic                   rsp_err_q;

    logic [TAG_TID_W-1:0]   rsp_tid;
    logic [TAG_DW_W-1:0]    rsp_dw;
    logic                   accept;
    logic                   last_pass;

    logic [NUM_LANES-1:0][DATA_W-1:0] buf_data;

    assign rsp_tid     = mem_tag_resp[TAG_TID_LSB +: TAG_TID_W];
    assign rsp_dw      = mem_tag_resp[TAG_DW_LSB +: TAG_DW_W];
    assign accept      = (state_q == ST_COLLECT) && mem_ack && (rsp_dw == pass_q) && pending_q[rsp_tid];
    assign pending_clr = pending_q & ~(NUM_LANES'(1) << rsp_tid);
    assign last_pass   = (pass_q == cnt_q);

    always_ff @(posedge clk) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = (start_exec != '0) ? ST_COLLECT : ST_DONE;
            ST_COLLECT: if (accept && (pending_clr == '0)) state_d = ST_WRITE;
            ST_WRITE:   if (vgpr_wr_ready) state_d = last_pass ? ST_DONE : ST_COLLECT;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            exec_q    <= '0;
            pending_q <= '0;
            dest_q    <= '0;
            cnt_q     <= '0;
            pass_q    <= '0;
            wfid_q    <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            // Anything not accepted is a drop, whatever the state.
            rsp_err_q <= mem_ack && !accept;
            if (state_q == ST_IDLE && start) begin
                exec_q    <= start_exec;
                pending_q <= start_exec;
                dest_q    <= start_vgpr_dest;
                cnt_q     <= start_dword_cnt;
                wfid_q    <= start_wfid;
                pass_q    <= '0;
            end
            if (accept) pending_q <= pending_clr;
            if (state_q == ST_WRITE && vgpr_wr_ready && !last_pass) begin
                pass_q    <= pass_q + 1'b1;
                pending_q <= exec_q;
            end
        end
    end

    mtbuf_rsp_lane_buf #(
        .LANES (NUM_LANES),
        .WIDTH (DATA_W),
        .IDX_W (TAG_TID_W)
    ) u_lane_buf (
        .clk   (clk),
        .we    (accept),
        .idx   (rsp_tid),
        .wdata (mem_rd_data),
        .rdata (buf_data)
    );

    assign busy         = (state_q != ST_IDLE);
    assign vgpr_wr_en   = (state_q == ST_WRITE);
    assign vgpr_wr_addr = dest_q + VGPR_ADDR_W'(pass_q);
    assign vgpr_wr_data = buf_data;
    assign vgpr_wr_mask = exec_q;
    assign done         = (state_q == ST_DONE);
    assign done_wfid    = wfid_q;
    assign rsp_err      = rsp_err_q;

endmodule

// File: tb/tb_mtbuf_rsp_collector.sv
// Scoreboard bench: stimulus pushes expected writes/dones, a negedge monitor pops and compares.
module tb_mtbuf_rsp_collector;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [63:0]   start_exec = '0;
    logic [9:0]    start_vgpr_dest = '0;
    logic [1:0]    start_dword_cnt = '0;
    logic [5:0]    start_wfid = '0;
    logic          busy;
    logic          mem_ack = 1'b0;
    logic [7:0]    mem_tag_resp = '0;
    logic [31:0]   mem_rd_data = '0;
    logic          vgpr_wr_en;
    logic          vgpr_wr_ready = 1'b1;
    logic [9:0]    vgpr_wr_addr;
    logic [2047:0] vgpr_wr_data;
    logic [63:0]   vgpr_wr_mask;
    logic          done;
    logic [5:0]    done_wfid;
    logic          rsp_err;

    mtbuf_rsp_collector dut (
        .clk(clk), .rst(rst), .start(start), .start_exec(start_exec),
        .start_vgpr_dest(start_vgpr_dest), .start_dword_cnt(start_dword_cnt),
        .start_wfid(start_wfid), .busy(busy), .mem_ack(mem_ack),
        .mem_tag_resp(mem_tag_resp), .mem_rd_data(mem_rd_data),
        .vgpr_wr_en(vgpr_wr_en), .vgpr_wr_ready(vgpr_wr_ready),
        .vgpr_wr_addr(vgpr_wr_addr), .vgpr_wr_data(vgpr_wr_data),
        .vgpr_wr_mask(vgpr_wr_mask), .done(done), .done_wfid(done_wfid),
        .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]    addr;
        logic [63:0]   mask;
        logic [2047:0] data;
    } wr_t;

    typedef struct {
        logic [5:0] wfid;
        bit         after_wr;
    } dn_t;

    wr_t wq[$];
    dn_t dq[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_wr_cyc = -10;
    int err_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every presented write (also while stalled) and every done.
    always @(negedge clk) begin
        if (rst) begin
            if (rsp_err) err_cnt++;
            if (vgpr_wr_en) begin
                if (wq.size() == 0) begin
                    chk("unexpected_write", 64'(vgpr_wr_addr), 64'h3ff_ffff);
                end else begin
                    automatic wr_t e = wq[0];
                    automatic bit ok = 1'b1;
                    automatic int bad = 0;
                    chk("wr_addr", 64'(vgpr_wr_addr), 64'(e.addr));
                    chk("wr_mask", vgpr_wr_mask, e.mask);
                    for (int l = 0; l < 64; l++)
                        if (e.mask[l] && vgpr_wr_data[l*32 +: 32] !== e.data[l*32 +: 32]) begin
                            ok = 1'b0;
                            bad = l;
                        end
                    checks++;
                    if (!ok) begin
                        failures++;
                        $display("FAIL wr_data lane %0d actual=%0h required=%0h", bad,
                                 vgpr_wr_data[bad*32 +: 32], e.data[bad*32 +: 32]);
                    end
                    if (vgpr_wr_ready) begin
                        void'(wq.pop_front());
                        last_wr_cyc = cyc;
                    end
                end
            end
            if (done) begin
                if (dq.size() == 0) begin
                    chk("unexpected_done", 64'(done_wfid), 64'hff);
                end else begin
                    automatic dn_t d = dq.pop_front();
                    chk("done_wfid", 64'(done_wfid), 64'(d.wfid));
                    if (d.after_wr) chk("done_latency", 64'(cyc - last_wr_cyc), 64'd1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [63:0] ex, input logic [9:0] dest,
                            input logic [1:0] cnt, input logic [5:0] wf);
        start = 1'b1; start_exec = ex; start_vgpr_dest = dest;
        start_dword_cnt = cnt; start_wfid = wf;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [1:0] dw, input logic [5:0] tid, input logic [31:0] d);
        mem_ack = 1'b1; mem_tag_resp = {dw, tid}; mem_rd_data = d;
        tick();
        mem_ack = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        chk(name, 64'(busy), 64'd0);
    endtask

    task automatic push_wr(input logic [9:0] a, input logic [63:0] m, input logic [2047:0] d);
        wr_t e;
        e.addr = a; e.mask = m; e.data = d;
        wq.push_back(e);
    endtask

    task automatic push_dn(input logic [5:0] wf, input bit aw);
        dn_t d;
        d.wfid = wf; d.after_wr = aw;
        dq.push_back(d);
    endtask

    initial begin
        logic [2047:0] dv;
        int e0;

        repeat (3) tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_wr_en", 64'(vgpr_wr_en), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("rst_done_wfid", 64'(done_wfid), 64'd0);
        rst = 1'b1;
        tick();

        // Full mask, one dword, reverse tid order
        dv = '0;
        for (int l = 0; l < 64; l++) dv[l*32 +: 32] = 32'hA000 + l;
        push_wr(10'd40, '1, dv);
        push_dn(6'd5, 1'b1);
        do_start('1, 10'd40, 2'd0, 6'd5);
        chk("busy_after_start", 64'(busy), 64'd1);
        for (int l = 63; l >= 0; l--) send(2'd0, 6'(l), 32'hA000 + l);
        wait_idle("idle_full");

        // Sparse mask, 4 dwords
        push_dn(6'd9, 1'b1);
        for (int p = 0; p < 4; p++) begin
            dv = '0;
            dv[0*32 +: 32] = 32'hB000_0000 | (p << 8) | 0;
            dv[2*32 +: 32] = 32'hB000_0000 | (p << 8) | 2;
            push_wr(10'(100 + p), 64'h5, dv);
        end
        do_start(64'h5, 10'd100, 2'd3, 6'd9);
        for (int p = 0; p < 4; p++) begin
            send(2'(p), 6'd2, 32'hB000_0000 | (p << 8) | 2);
            send(2'(p), 6'd0, 32'hB000_0000 | (p << 8) | 0);
            tick();
        end
        wait_idle("idle_sparse");

        // Error drops: non-exec lane, wrong dword, duplicate
        dv = '0;
        dv[0*32 +: 32] = 32'hC0C0_0000;
        dv[2*32 +: 32] = 32'hC2C2_0000;
        push_wr(10'd200, 64'h5, dv);
        push_dn(6'd3, 1'b1);
        do_start(64'h5, 10'd200, 2'd0, 6'd3);
        e0 = err_cnt;
        send(2'd0, 6'd0, 32'hC0C0_0000);
        send(2'd0, 6'd1, 32'hDEAD_0001);
        send(2'd1, 6'd2, 32'hDEAD_0002);
        send(2'd0, 6'd0, 32'hDEAD_0003);
        tick();
        chk("rsp_err_count", 64'(err_cnt - e0), 64'd3);
        chk("still_collecting", 64'(busy && !vgpr_wr_en), 64'd1);
        send(2'd0, 6'd2, 32'hC2C2_0000);
        wait_idle("idle_err");

        // Back-pressure plus ignored start
        dv = '0;
        dv[3*32 +: 32] = 32'h3333;
        push_wr(10'd300, 64'h8, dv);
        push_dn(6'd7, 1'b1);
        vgpr_wr_ready = 1'b0;
        do_start(64'h8, 10'd300, 2'd0, 6'd7);
        send(2'd0, 6'd3, 32'h3333);
        for (int k = 0; k < 5; k++) begin
            chk("bp_wr_en_held", 64'(vgpr_wr_en), 64'd1);
            if (k == 2) begin
                start = 1'b1; start_exec = '1; start_vgpr_dest = 10'd9;
                start_dword_cnt = 2'd2; start_wfid = 6'd20;
            end
            tick();
            start = 1'b0;
        end
        vgpr_wr_ready = 1'b1;
        wait_idle("idle_bp");

        // Zero exec: done without write
        push_dn(6'd11, 1'b0);
        do_start('0, 10'd50, 2'd0, 6'd11);
        chk("zero_exec_no_wr", 64'(vgpr_wr_en), 64'd0);
        wait_idle("idle_zero");

        // Address wrap 1023 -> 0
        dv = '0;
        dv[31:0] = 32'h1;
        push_wr(10'd1023, 64'h1, dv);
        dv[31:0] = 32'h2;
        push_wr(10'd0, 64'h1, dv);
        push_dn(6'd12, 1'b1);
        do_start(64'h1, 10'd1023, 2'd1, 6'd12);
        send(2'd0, 6'd0, 32'h1);
        tick();
        send(2'd1, 6'd0, 32'h2);
        wait_idle("idle_wrap");

        // Reset mid-COLLECT, then fresh load
        do_start('1, 10'd500, 2'd0, 6'd13);
        for (int l = 0; l < 10; l++) send(2'd0, 6'(l), 32'hE000 + l);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_wr_en", 64'(vgpr_wr_en), 64'd0);
        dv = '0;
        dv[0*32 +: 32] = 32'hF000;
        dv[1*32 +: 32] = 32'hF001;
        push_wr(10'd7, 64'h3, dv);
        push_dn(6'd14, 1'b1);
        do_start(64'h3, 10'd7, 2'd0, 6'd14);
        send(2'd0, 6'd1, 32'hF001);
        send(2'd0, 6'd0, 32'hF000);
        wait_idle("idle_fresh");

        // Response while idle is dropped
        e0 = err_cnt;
        send(2'd0, 6'd0, 32'h5);
        tick();
        chk("idle_ack_err", 64'(err_cnt - e0), 64'd1);

        repeat (3) tick();
        chk("wr_queue_empty", 64'(wq.size()), 64'd0);
        chk("done_queue_empty", 64'(dq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
